// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encodings, owner codes
// and the IDLE-state arbitration rule.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT_IF = 2'd1,
    ARB_WAIT_DM = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  // Data side wins contention unless fetch has been starved long enough.
  function automatic arb_owner_e pick_owner(input logic if_req,
                                            input logic dm_req,
                                            input logic starve_sat);
    if (if_req && (!dm_req || starve_sat)) return OWN_IF;
    return OWN_DM;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive arbitrations fetch has lost to the data side.
// sat flags that fetch is owed the next contended grant.
module arb_starve_counter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sat = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one
// transaction in flight, data priority with bounded fetch starvation.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pipe_flush,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_e state, state_n;
  logic       drop, drop_n;
  logic       starve_sat;
  arb_owner_e winner;

  arb_starve_counter #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (dm_gnt && if_req),
    .clr (if_gnt),
    .sat (starve_sat)
  );

  assign winner = pick_owner(if_req, dm_req, starve_sat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      drop  <= drop_n;
    end
  end

  // NOTE: every output and next-state value gets a default before the case so
  // no path through this block can infer a latch.
  always_comb begin
    state_n   = state;
    drop_n    = drop;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    dm_rdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;

    // The issue path is combinational, so hold the bus quiet while in reset.
    if (!rst) begin
      unique case (state)
        ARB_IDLE: begin
          if (if_req || dm_req) begin
            mem_req = 1'b1;
            if (winner == OWN_IF) begin
              mem_addr = if_addr;
              if (mem_ready) begin
                if_gnt  = 1'b1;
                state_n = ARB_WAIT_IF;
                drop_n  = pipe_flush;
              end
            end else begin
              mem_we    = dm_we;
              mem_addr  = dm_addr;
              mem_wdata = dm_wdata;
              mem_wstrb = dm_we ? dm_wstrb : '0;
              if (mem_ready) begin
                dm_gnt  = 1'b1;
                state_n = ARB_WAIT_DM;
              end
            end
          end
        end

        ARB_WAIT_IF: begin
          if (mem_rvalid) begin
            // A flush arriving with the response still makes it stale.
            if_rvalid = !(drop || pipe_flush);
            if_rdata  = if_rvalid ? mem_rdata : '0;
            drop_n    = 1'b0;
            state_n   = ARB_IDLE;
          end else if (pipe_flush) begin
            drop_n = 1'b1;
          end
        end

        ARB_WAIT_DM: begin
          if (mem_rvalid) begin
            dm_rvalid = 1'b1;
            dm_rdata  = mem_rdata;
            state_n   = ARB_IDLE;
          end
        end

        default: state_n = ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic, compared against a transaction-level model of the port.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_flush;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [SW-1:0] dm_wstrb;
  logic          dm_gnt, dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_ready, mem_rvalid;
  logic [DW-1:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  // Transaction-level model: is a transaction outstanding, whose, how many
  // contended grants fetch has lost, and whether the fetch response is stale.
  bit m_busy;
  bit m_own_dm;
  bit m_pend_we;
  int m_starve;
  bit m_drop;

  bit last_if_gnt, last_dm_gnt;
  bit grant_log[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .pipe_flush(pipe_flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    pipe_flush = 0; if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    mem_ready = 1; mem_rvalid = 0; mem_rdata = '0;
  endtask

  // Called just after a falling edge with inputs driven: check outputs, step
  // the model across the rising edge, return at the next falling edge.
  task automatic cycle(input string tag);
    bit win_if, e_req, e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv;
    #1;
    if (rst) begin
      e_if_gnt = 0; e_dm_gnt = 0;
      check({tag, ":rst_outs"},
            {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we},
            64'd0);
      check({tag, ":rst_bus"}, {mem_addr, mem_wdata} | {if_rdata, dm_rdata} | mem_wstrb, 64'd0);
    end else begin
      win_if   = if_req && (!dm_req || m_starve >= STARVE_MAX);
      e_req    = !m_busy && (if_req || dm_req);
      e_if_gnt = e_req && win_if && mem_ready;
      e_dm_gnt = e_req && !win_if && mem_ready;
      e_if_rv  = m_busy && !m_own_dm && mem_rvalid && !m_drop && !pipe_flush;
      e_dm_rv  = m_busy && m_own_dm && mem_rvalid;
      check({tag, ":mem_req"},   mem_req,   e_req);
      check({tag, ":if_gnt"},    if_gnt,    e_if_gnt);
      check({tag, ":dm_gnt"},    dm_gnt,    e_dm_gnt);
      check({tag, ":if_rvalid"}, if_rvalid, e_if_rv);
      check({tag, ":dm_rvalid"}, dm_rvalid, e_dm_rv);
      if (e_req) begin
        check({tag, ":mem_addr"},  mem_addr,  win_if ? if_addr : dm_addr);
        check({tag, ":mem_we"},    mem_we,    !win_if && dm_we);
        check({tag, ":mem_wstrb"}, mem_wstrb, (!win_if && dm_we) ? dm_wstrb : '0);
        if (!win_if && dm_we) check({tag, ":mem_wdata"}, mem_wdata, dm_wdata);
      end
      if (e_if_rv) check({tag, ":if_rdata"}, if_rdata, mem_rdata);
      if (e_dm_rv && !m_pend_we) check({tag, ":dm_rdata"}, dm_rdata, mem_rdata);
    end
    last_if_gnt = e_if_gnt;
    last_dm_gnt = e_dm_gnt;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_starve = 0; m_drop = 0;
    end else if (!m_busy) begin
      if (e_if_gnt) begin
        m_busy = 1; m_own_dm = 0; m_starve = 0; m_drop = pipe_flush;
      end else if (e_dm_gnt) begin
        m_busy = 1; m_own_dm = 1; m_pend_we = dm_we;
        if (if_req && m_starve < STARVE_MAX) m_starve++;
      end
    end else begin
      if (!m_own_dm && pipe_flush) m_drop = 1;
      if (mem_rvalid) begin
        m_busy = 0; m_drop = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle("reset");
    rst = 0;
  endtask

  // Both sides requesting continuously, response latency 1; logs n grants.
  task automatic collect(input int n, input string tag);
    int got = 0;
    if_req = 1; dm_req = 1; dm_we = 0; mem_ready = 1;
    for (int c = 0; c < 8 * n && got < n; c++) begin
      mem_rvalid = m_busy;
      mem_rdata  = $urandom;
      cycle(tag);
      if (last_if_gnt || last_dm_gnt) begin
        grant_log.push_back(last_if_gnt);
        got++;
      end
    end
    check({tag, ":grant_count"}, got, n);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    m_busy = 0; m_own_dm = 0; m_pend_we = 0; m_starve = 0; m_drop = 0;
    @(negedge clk);
    cycle("reset");
    rst = 0;

    // Fetch alone, response three cycles after the grant.
    if_req = 1; if_addr = 32'h100;
    #1 check("ifonly:gnt0", if_gnt, 1'b1);
    cycle("ifonly_c0");
    if_req = 0;
    cycle("ifonly_c1");
    cycle("ifonly_c2");
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    #1 check("ifonly:rvalid3", if_rvalid, 1'b1);
    check("ifonly:rdata3", if_rdata, 32'hDEAD_BEEF);
    check("ifonly:dm_rvalid", dm_rvalid, 1'b0);
    cycle("ifonly_c3");
    mem_rvalid = 0;

    // Data write.
    dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'h1234_5678; dm_wstrb = 4'b0011;
    #1 check("wr:mem_we", mem_we, 1'b1);
    check("wr:mem_addr", mem_addr, 32'h2000);
    check("wr:mem_wdata", mem_wdata, 32'h1234_5678);
    check("wr:mem_wstrb", mem_wstrb, 4'b0011);
    cycle("wr_issue");
    dm_req = 0; dm_we = 0; mem_rvalid = 1;
    #1 check("wr:ack", dm_rvalid, 1'b1);
    cycle("wr_ack");
    mem_rvalid = 0;

    // Data read with strobes left high.
    dm_req = 1; dm_we = 0; dm_addr = 32'h2004; dm_wstrb = 4'hF;
    #1 check("rd:mem_req", mem_req, 1'b1);
    check("rd:mem_wstrb", mem_wstrb, 4'h0);
    cycle("rd_issue");
    dm_req = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    cycle("rd_resp");
    mem_rvalid = 0; dm_wstrb = '0;

    // Flush one cycle after grant, then flush in the grant cycle.
    for (int k = 0; k < 2; k++) begin
      if_req = 1; if_addr = 32'h300 + 32'(k * 4); pipe_flush = (k == 1);
      cycle("flush_gnt");
      if_req = 0; pipe_flush = (k == 0);
      cycle("flush_wait");
      pipe_flush = 0; mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
      #1 check("flush:dropped", if_rvalid, 1'b0);
      cycle("flush_resp");
      mem_rvalid = 0; if_req = 1;
      #1 check("flush:regrant", if_gnt, 1'b1);
      cycle("flush_regnt");
      if_req = 0; mem_rvalid = 1; mem_rdata = 32'h0BAD_C0DE;
      #1 check("flush:resume", if_rvalid, 1'b1);
      cycle("flush_resume");
      mem_rvalid = 0;
    end

    // Contention from a cleared counter: DM x4 then IF, twice.
    do_reset();
    grant_log.delete();
    collect(10, "cont");
    for (int i = 0; i < grant_log.size(); i++)
      check($sformatf("cont:order%0d", i), grant_log[i], (i % 5) == 4);
    mem_rvalid = 1;
    cycle("cont_drain");

    // Backpressure must not age the counter: DM,DM, stall, then DM,DM,IF.
    do_reset();
    grant_log.delete();
    collect(2, "bp_pre");
    mem_rvalid = 1;
    cycle("bp_drain");
    mem_rvalid = 0; mem_ready = 0; if_req = 1; dm_req = 1;
    for (int i = 0; i < 5; i++) begin
      #1 check("bp:no_gnt", {if_gnt, dm_gnt}, 2'b00);
      cycle("bp_stall");
    end
    collect(3, "bp_post");
    check("bp:order", {grant_log[2], grant_log[3], grant_log[4]}, 3'b001);
    mem_rvalid = 1;
    cycle("bp_drain2");

    // Reset while waiting on a data read, then a late response.
    idle_inputs();
    dm_req = 1;
    cycle("rst_issue");
    dm_req = 0;
    cycle("rst_wait");
    rst = 1;
    #1 check("rstmid:outs", {dm_rvalid, mem_req, dm_gnt, if_gnt}, 4'b0000);
    cycle("rst_mid");
    rst = 0; mem_rvalid = 1; mem_rdata = 32'h7777_7777;
    #1 check("rstmid:late_rvalid", dm_rvalid, 1'b0);
    cycle("rst_late");
    mem_rvalid = 0; if_req = 1;
    #1 check("rstmid:idle_gnt", if_gnt, 1'b1);
    cycle("rst_after");
    if_req = 0; mem_rvalid = 1;
    cycle("rst_after_resp");

    // Random traffic with withdrawals, stalls, strays, flushes and resets.
    idle_inputs();
    for (int c = 0; c < 4000; c++) begin
      if (!if_req || last_if_gnt) begin
        if_req  = $urandom_range(0, 99) < 60;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end else if ($urandom_range(0, 99) < 3) begin
        if_req = 0;
      end
      if (!dm_req || last_dm_gnt) begin
        dm_req   = $urandom_range(0, 99) < 60;
        dm_we    = $urandom_range(0, 1) == 1;
        dm_addr  = $urandom & 32'hFFFF_FFFC;
        dm_wdata = $urandom;
        dm_wstrb = SW'($urandom);
      end else if ($urandom_range(0, 99) < 3) begin
        dm_req = 0;
      end
      mem_ready  = $urandom_range(0, 99) < 75;
      mem_rvalid = m_busy ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 5);
      mem_rdata  = $urandom;
      pipe_flush = !mem_rvalid && ($urandom_range(0, 99) < 10);
      rst        = $urandom_range(0, 999) < 5;
      cycle("rand");
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
